// File: rtl/press_arbiter.sv
// press_arbiter: debounces two active-low player keys, decides each reaction round
// and keeps thermometer scores for both players.
module press_arbiter #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int WIN_SCORE       = 5
) (
    input  logic       CLOCK50,
    input  logic       reset,
    input  logic       p1_n,
    input  logic       p2_n,
    input  logic       arm,
    input  logic       go,
    input  logic       clear_scores,
    output logic [1:0] winner,
    output logic       false_start,
    output logic       round_done,
    output logic       counter_stop,
    output logic [4:0] LED1,
    output logic [4:0] LED2,
    output logic       match_over,
    output logic       busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] LIVE  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0] keys, press, state, res;
    logic       decide;
    logic [4:0] led1_n, led2_n;

    assign keys = {p2_n, p1_n};

    for (genvar k = 0; k < 2; k++) begin : g_key
        logic [SYNC_STAGES-1:0] sync;
        logic [CW-1:0]          cnt;
        logic                   deb, p;
        assign press[k] = p;
        // a press is the debounced 1->0 edge, so a held key yields only one
        always_ff @(posedge CLOCK50 or posedge reset)
            if (reset) begin
                sync <= '1;
                cnt  <= '0;
                deb  <= 1'b1;
                p    <= 1'b0;
            end else begin
                sync <= {sync[SYNC_STAGES-2:0], keys[k]};
                p    <= 1'b0;
                if (sync[SYNC_STAGES-1] == deb)
                    cnt <= '0;
                else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt <= '0;
                    deb <= sync[SYNC_STAGES-1];
                    p   <= deb;
                end else
                    cnt <= cnt + 1'b1;
            end
    end

    // before go a press hands the round to the opponent
    always_comb begin
        decide = (state == ARMED || state == LIVE) && (press != 2'b00);
        res    = (press == 2'b11) ? 2'b11 : ((state == LIVE) == press[0]) ? 2'b01 : 2'b10;
        led1_n = {LED1[3:0], 1'b1};
        led2_n = {1'b1, LED2[4:1]};
    end

    assign busy = (state == ARMED) || (state == LIVE);

    always_ff @(posedge CLOCK50 or posedge reset)
        if (reset || clear_scores) begin
            state        <= IDLE;
            winner       <= 2'b00;
            false_start  <= 1'b0;
            round_done   <= 1'b0;
            counter_stop <= 1'b0;
            LED1         <= '0;
            LED2         <= '0;
            match_over   <= 1'b0;
        end else begin
            round_done <= 1'b0;
            if ((state == IDLE || state == DONE) && arm && !match_over) begin
                state        <= ARMED;
                winner       <= 2'b00;
                false_start  <= 1'b0;
                counter_stop <= 1'b0;
            end else if (decide) begin
                state        <= DONE;
                winner       <= res;
                false_start  <= (state == ARMED);
                round_done   <= 1'b1;
                counter_stop <= 1'b1;
                if (res == 2'b01) begin
                    LED1       <= led1_n;
                    match_over <= match_over | led1_n[WIN_SCORE-1];
                end
                if (res == 2'b10) begin
                    LED2       <= led2_n;
                    match_over <= match_over | led2_n[5-WIN_SCORE];
                end
            end else if (state == ARMED && go)
                state <= LIVE;
        end
endmodule
